// File: rtl/uart_receive.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// single-entry output register that reports overrun and framing errors as pulses.
module uart_receive #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [2:0]    index;
    logic [7:0]    shift;
    logic          rx_meta;
    logic          rx_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Output handshake: a byte transfers on any rising edge where rx_valid and
    // rx_ready are both 1; rx_data is held unchanged until that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            index     <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state   <= START;
                        count   <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (count == HALF_LAST) begin
                        count <= '0;
                        index <= 3'd0;
                        if (!rx_sync) begin
                            state <= DATA;
                        end else begin
                            // line went back high: a glitch, not a start bit
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DATA: begin
                    if (count == FULL_LAST) begin
                        count        <= '0;
                        shift[index] <= rx_sync;
                        if (index == 3'd7) begin
                            state <= STOP;
                        end else begin
                            index <= index + 3'd1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                STOP: begin
                    if (count == FULL_LAST) begin
                        count   <= '0;
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                        if (!rx_sync) begin
                            frame_err <= 1'b1;
                        end else if (!rx_valid || rx_ready) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive at 16 clocks per bit: frame-level timing model compared
// every cycle, plus literal expectations on delivered bytes and pulse counts.
module tb_uart_receive;
  localparam int C = 16;
  localparam int EV_ON = 0;
  localparam int EV_OFF = 1;
  localparam int EV_STOP = 2;

  typedef struct {
    int         edge_n;
    int         kind;
    logic [7:0] data;
    logic       stop;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  ev_t        ev_q[$];
  logic [7:0] exp_q[$];

  // model state
  logic       started = 1'b0;
  logic       mv = 1'b0;
  logic [7:0] md = 8'h00;
  logic       mfe = 1'b0;
  logic       mov = 1'b0;
  logic       mbusy = 1'b0;
  logic       r_cap = 1'b0;
  logic       rd_cap = 1'b0;
  logic       prev_v = 1'b0;

  // DUT-observed pulse counters
  int n_vhigh = 0;
  int n_fe = 0;
  int n_ov = 0;

  uart_receive #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_busy(rx_busy),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    r_cap = reset;
    rd_cap = rx_ready;
  end

  // model update for the edge just taken, then compare
  always @(negedge clk) begin
    logic hs;
    logic loaded;
    logic [7:0] e;
    if (r_cap) begin
      mv = 1'b0; md = 8'h00; mfe = 1'b0; mov = 1'b0; mbusy = 1'b0;
      ev_q.delete();
      started = 1'b1;
    end else if (started) begin
      hs = mv && rd_cap;
      loaded = 1'b0;
      mfe = 1'b0;
      mov = 1'b0;
      for (int i = ev_q.size() - 1; i >= 0; i--) begin
        if (ev_q[i].edge_n == cyc) begin
          case (ev_q[i].kind)
            EV_ON:  mbusy = 1'b1;
            EV_OFF: mbusy = 1'b0;
            default: begin
              mbusy = 1'b0;
              if (!ev_q[i].stop) mfe = 1'b1;
              else if (!mv || hs) begin md = ev_q[i].data; loaded = 1'b1; end
              else mov = 1'b1;
            end
          endcase
          ev_q.delete(i);
        end
      end
      if (loaded) mv = 1'b1;
      else if (hs) mv = 1'b0;
    end
    if (started) begin
      total++;
      if (rx_valid !== mv || rx_data !== md || frame_err !== mfe || overrun !== mov || rx_busy !== mbusy) begin
        bad++;
        $display("FAIL outputs@%0d: got v=%b d=%h fe=%b ov=%b busy=%b want v=%b d=%h fe=%b ov=%b busy=%b",
                 cyc, rx_valid, rx_data, frame_err, overrun, rx_busy, mv, md, mfe, mov, mbusy);
      end
      if (rx_valid === 1'b1 && !prev_v) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL byte_order: got %h want no byte", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            bad++;
            $display("FAIL byte_order: got %h want %h", rx_data, e);
          end
        end
      end
      prev_v = (rx_valid === 1'b1);
      if (rx_valid === 1'b1) n_vhigh++;
      if (frame_err === 1'b1) n_fe++;
      if (overrun === 1'b1) n_ov++;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Start edge reaches the first flop at edge k = cyc+1; the stop sample is
  // two sync edges plus half a bit plus nine bits later.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    int stop_edge;
    stop_edge = cyc + 3 + C / 2 + 9 * C;
    ev_q.push_back('{cyc + 3, EV_ON, 8'h00, 1'b1});
    ev_q.push_back('{stop_edge, EV_STOP, b, stop});
    if (!stop) begin
      // the low stop bit still reads as a start after the stop sample, then is rejected
      ev_q.push_back('{stop_edge + 1, EV_ON, 8'h00, 1'b1});
      ev_q.push_back('{stop_edge + 1 + C / 2, EV_OFF, 8'h00, 1'b1});
    end
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(C);
    end
    rx = stop;
    tick(C);
    rx = 1'b1;
  endtask

  task automatic send_glitch(input int len);
    ev_q.push_back('{cyc + 3, EV_ON, 8'h00, 1'b1});
    ev_q.push_back('{cyc + 3 + C / 2, EV_OFF, 8'h00, 1'b1});
    rx = 1'b0;
    tick(len);
    rx = 1'b1;
  endtask

  initial begin
    int v0, fe0, ov0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check("reset_data", {24'd0, rx_data}, 32'h00);
    check("reset_valid", {31'd0, rx_valid}, 32'h0);
    check("reset_busy", {31'd0, rx_busy}, 32'h0);
    tick(20);

    // 'H' with consumer ready
    v0 = n_vhigh; fe0 = n_fe; ov0 = n_ov;
    exp_q.push_back(8'h48);
    send_frame(8'h48, 1'b1);
    tick(20);
    check("h_data", {24'd0, rx_data}, 32'h48);
    check("h_valid_cycles", n_vhigh - v0, 1);
    check("h_errors", (n_fe - fe0) + (n_ov - ov0), 0);

    // overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    ov0 = n_ov;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(20);
    check("ovr_data", {24'd0, rx_data}, 32'hA5);
    check("ovr_valid", {31'd0, rx_valid}, 32'h1);
    check("ovr_pulses", n_ov - ov0, 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    check("ovr_cleared", {31'd0, rx_valid}, 32'h0);
    rx_ready = 1'b1;
    tick(10);

    // stop bit forced low
    v0 = n_vhigh; fe0 = n_fe;
    send_frame(8'h55, 1'b0);
    tick(30);
    check("ferr_pulses", n_fe - fe0, 1);
    check("ferr_valid_cycles", n_vhigh - v0, 0);
    check("ferr_data", {24'd0, rx_data}, 32'hA5);

    // short low glitch
    v0 = n_vhigh; fe0 = n_fe; ov0 = n_ov;
    send_glitch(4);
    tick(30);
    check("glitch_activity", (n_vhigh - v0) + (n_fe - fe0) + (n_ov - ov0), 0);
    check("glitch_busy", {31'd0, rx_busy}, 32'h0);

    // reset during data bit 3 of 0xFF, then a clean 0x0D
    v0 = n_vhigh; fe0 = n_fe;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        tick(72);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
    join
    tick(20);
    check("rst_no_output", (n_vhigh - v0) + (n_fe - fe0), 0);
    check("rst_data_cleared", {24'd0, rx_data}, 32'h00);
    exp_q.push_back(8'h0D);
    send_frame(8'h0D, 1'b1);
    tick(20);
    check("rst_next_data", {24'd0, rx_data}, 32'h0D);
    check("rst_next_valid", n_vhigh - v0, 1);

    // back-to-back stream "G1\n"
    v0 = n_vhigh; fe0 = n_fe; ov0 = n_ov;
    exp_q.push_back(8'h47);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h0A);
    send_frame(8'h47, 1'b1);
    send_frame(8'h31, 1'b1);
    send_frame(8'h0A, 1'b1);
    tick(20);
    check("stream_valid_cycles", n_vhigh - v0, 3);
    check("stream_errors", (n_fe - fe0) + (n_ov - ov0), 0);
    check("stream_last", {24'd0, rx_data}, 32'h0A);
    check("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_receive.md
UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 The block SHALL have one clock, clk, and one synchronous active-high reset, reset.
REQ-002 Parameter CLKS_PER_BIT SHALL default to 868, the clk cycles per bit (100 MHz / 115200 baud); legal values are even and >= 8.
REQ-003 Port clk SHALL be input, width 1: the system clock, with all logic on its rising edge.
REQ-004 Port reset SHALL be input, width 1: synchronous, active-high reset.
REQ-005 Port rx SHALL be input, width 1: the asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 Port rx_data SHALL be output, width 8: the received byte, valid while rx_valid=1.
REQ-007 Port rx_valid SHALL be output, width 1: a byte is held for the consumer.
REQ-008 Port rx_ready SHALL be input, width 1: the consumer accepts the byte when rx_valid=1 and rx_ready=1 on a rising edge.
REQ-009 Port rx_busy SHALL be output, width 1: high while the state is not IDLE.
REQ-010 Port frame_err SHALL be output, width 1: a one-cycle pulse when the stop-bit sample is 0.
REQ-011 Port overrun SHALL be output, width 1: a one-cycle pulse when a completed byte is dropped.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all FSM decisions SHALL use the synchronized value.
REQ-013 The FSM SHALL have four states: IDLE, START, DATA, STOP, with a bit-period counter and a 3-bit bit index.
REQ-014 IDLE: when the synchronized rx=0, the FSM SHALL go to START and clear the counter.
REQ-015 START: at counter = CLKS_PER_BIT/2-1, the FSM SHALL re-sample the line. If the line is 0, it SHALL go to DATA, clear the counter and set the index to 0. If the line is 1, it SHALL return to IDLE as a glitch, with no output activity.
REQ-016 DATA: at counter = CLKS_PER_BIT-1, the FSM SHALL sample the line into shift-register bit[index] (LSB first) and clear the counter. After index 7, it SHALL go to STOP.
REQ-017 STOP: at counter = CLKS_PER_BIT-1, the FSM SHALL sample the line and return to IDLE on the same edge.
- Sample = 1: the byte is delivered per REQ-018/019.
- Sample = 0: frame_err pulses for 1 cycle and the byte is discarded, with no effect on rx_valid or rx_data.
REQ-018 Delivery with rx_valid=0, or with rx_valid=1 and rx_ready=1 on the same edge: rx_data SHALL load the byte and rx_valid SHALL be 1 on the next cycle.
REQ-019 Delivery with rx_valid=1 and rx_ready=0: overrun SHALL pulse for 1 cycle, the new byte SHALL be dropped, and rx_data and rx_valid SHALL be unchanged.
REQ-020 A handshake with no delivery on the same edge SHALL clear rx_valid on the next cycle.
REQ-021 rx_data SHALL be stable while rx_valid=1 and not handshaken.
REQ-022 Bit sampling SHALL occur mid-bit: the sample for data bit n is taken (1.5+n)*CLKS_PER_BIT cycles (±3) after the start edge reaches the pin.
REQ-023 rx_valid SHALL assert no later than 9.5*CLKS_PER_BIT+4 cycles after the start edge.
REQ-024 The receiver SHALL accept back-to-back frames: a falling edge immediately after the stop-bit midpoint SHALL be detected.
REQ-025 The FSM SHALL NOT stall on rx_ready; reception continues regardless of consumer state.

Reset
REQ-026 While reset=1, the following SHALL hold on the next edge:
- state = IDLE; counter and index = 0.
- synchronizer = 1.
- rx_data = 8'h00, rx_valid = 0, rx_busy = 0, frame_err = 0, overrun = 0.
REQ-027 A reset mid-frame SHALL abandon the frame, with no delivery and no error pulse. After release, the FSM SHALL resynchronize on the next falling edge of a line held high for at least 2 cycles.

Verification (CLKS_PER_BIT=16)
REQ-028 With rx_ready=1, send frame 0x48 ('H'). Required:
- rx_valid pulses for exactly 1 cycle.
- rx_data = 8'h48.
- frame_err = 0, overrun = 0.
REQ-029 With rx_ready=0, send 0xA5 then 0x3C back-to-back. Required:
- rx_data stays 8'hA5 and rx_valid stays 1.
- overrun pulses once at the 0x3C stop sample.
- Raising rx_ready for one cycle then clears rx_valid.
REQ-030 Send 0x55 with the stop bit forced to 0. Required: frame_err pulses once, rx_valid stays 0, and rx_data is unchanged.
REQ-031 Drive rx low for 4 cycles, then high. Required: the FSM returns to IDLE after START, and rx_valid, frame_err and overrun all stay 0.
REQ-032 Assert reset for 1 cycle during data bit 3 of 0xFF, then send 0x0D. Required: no output from 0xFF, then rx_valid with rx_data = 8'h0D.
REQ-033 With rx_ready=1, stream "G1\n". Required: three rx_valid pulses carrying 0x47, 0x31, 0x0A in order, with no errors.
